mdu_hilo: RTL and testbench

//  Multi-cycle multiply/divide unit that owns the HI/LO register pair for the 8-bit MIPS datapath.
//  It accepts MUL/DIV/DIVU using the ALUop encoding the ALU already uses, and iterates one bit per cycle.
//  It writes the 16-bit product, or quotient/remainder, into LO/HI.
//  It serves MFHI/MFLO (continuous outputs) and MTHI/MTLO (write ports) for the control unit.

---
 rtl/mdu_hilo.sv | 203 ++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit that owns the HI/LO register pair.
//   Handles one operand bit per cycle. Supported ops: MUL (unsigned shift-add),
//   DIVU (restoring division) and DIV (signed, built on magnitude restoring
//   division plus a one-cycle sign fix-up). It also provides MTHI/MTLO write
//   ports and continuous HI/LO read-out for MFHI/MFLO.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, ALUop      operation request: 0100 MUL, 0101 DIV, 0110 DIVU
//   A, B              multiplicand/dividend, multiplier/divisor (latched at accept)
//   hi_we, lo_we      MTHI/MTLO strobes, honoured only while idle
//   wdata             MTHI/MTLO data
//   busy              high whenever the unit is not idle
//   done              one-cycle pulse in which HI/LO show the new result
//   div_by_zero       flags a DIV/DIVU with B == 0; cleared by the next accepted op
//   HI, LO            result registers (product high/low, or remainder/quotient)
module mdu_hilo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_DIVU = 4'b0110;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // multiplier / dividend, shifted into quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sdiv_q, sdiv_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             op_valid;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             fits;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    sdiv_d  = sdiv_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    op_valid = (ALUop == OP_MUL) || (ALUop == OP_DIV) || (ALUop == OP_DIVU);

    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, acc, quo} right by one.
    mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    rem_sh   = {acc_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    fits     = ~rem_diff[WIDTH];

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && op_valid) begin
          dbz_d  = 1'b0;
          acc_d  = '0;
          cnt_d  = CNT_LAST;
          quo_d  = A;
          opb_d  = B;
          sdiv_d = (ALUop == OP_DIV);
          qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_d = A[WIDTH-1];
          if (ALUop == OP_MUL) begin
            state_d = S_MUL;
          end else if (B == '0) begin
            // Divide by zero finishes immediately; the result overrides any
            // MT write issued in the same cycle.
            state_d = S_DONE;
            hi_d    = A;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_DIV;
            if (ALUop == OP_DIV) begin
              quo_d = mag(A);
              opb_d = mag(B);
            end
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          hi_d    = mul_sum[WIDTH:1];
          lo_d    = {mul_sum[0], quo_q[WIDTH-1:1]};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        acc_d = fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        if (cnt_q == '0) begin
          if (sdiv_q) begin
            state_d = S_FIX;
          end else begin
            hi_d    = fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_d    = {quo_q[WIDTH-2:0], fits};
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -acc_q : acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      sdiv_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      sdiv_q  <= sdiv_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed bench for mdu_hilo. A behavioural model
// tracks, per accepted op, its latency and arithmetic result. A single compare
// process checks every DUT output against the model on each falling edge.
module tb_mdu_hilo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ALUop = 4'd0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic       hi_we = 1'b0;
  logic       lo_we = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_hilo #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUop(ALUop), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cyc counts cycles since the accepting edge (1 = first cycle after it);
  // the op is busy for cycles 1..m_lat and done is high in cycle m_lat.
  bit         m_active = 1'b0;
  int         m_cyc = 0;
  int         m_lat = 0;
  logic [7:0] m_hi = 8'd0, m_lo = 8'd0, p_hi = 8'd0, p_lo = 8'd0;
  bit         m_dbz = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int         lat, sa, sb, q, r;
    logic [15:0] prod;
    logic [7:0]  rh, rl;
    bit          dz;
    if (rst) begin
      m_active <= 1'b0; m_cyc <= 0; m_lat <= 0;
      m_hi <= 8'd0; m_lo <= 8'd0; m_dbz <= 1'b0;
    end else if (!m_active) begin
      if (hi_we) m_hi <= wdata;
      if (lo_we) m_lo <= wdata;
      if (start && (ALUop == 4'b0100 || ALUop == 4'b0101 || ALUop == 4'b0110)) begin
        dz = 1'b0;
        if (ALUop != 4'b0100 && B == 8'd0) begin
          lat = 1; rh = A; rl = 8'hFF; dz = 1'b1;
        end else if (ALUop == 4'b0100) begin
          prod = 16'(A * B);
          lat = 9; rh = prod[15:8]; rl = prod[7:0];
        end else if (ALUop == 4'b0110) begin
          lat = 9; rl = A / B; rh = A % B;
        end else begin
          sa = $signed(A); sb = $signed(B);
          q = sa / sb; r = sa % sb;
          lat = 10; rl = q[7:0]; rh = r[7:0];
        end
        m_active <= 1'b1; m_cyc <= 1; m_lat <= lat; m_dbz <= dz;
        p_hi <= rh; p_lo <= rl;
        if (lat == 1) begin
          m_hi <= rh; m_lo <= rl;
        end
      end
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == m_lat) begin
        m_hi <= p_hi; m_lo <= p_lo;
      end else if (m_cyc + 1 > m_lat) begin
        m_active <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_active);
      chk("done", done, (m_active && m_cyc == m_lat));
      chk("div_by_zero", div_by_zero, m_dbz);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  // Issue one op at posedge+2 in idle; returns after done, at posedge+2 of the
  // following idle cycle. Checks latency and result against literals.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] exp_hi,
                        input logic [7:0] exp_lo, input bit exp_dbz, input string nm);
    int n;
    start = 1'b1; ALUop = op; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n > 20) begin
      chk({nm, "_timeout"}, 1, 0);
    end else begin
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_HI"}, HI, exp_hi);
      chk({nm, "_LO"}, LO, exp_lo);
      chk({nm, "_dbz"}, div_by_zero, exp_dbz);
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 6)
      0: pick = 8'h00;
      1: pick = 8'h80;
      2: pick = 8'hFF;
      3: pick = 8'h01;
      default: pick = 8'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_HI", HI, 0);
    chk("reset_LO", LO, 0);
    @(posedge clk); #2;

    run_op(4'b0100, 8'hFF, 8'hFF, 9, 8'hFE, 8'h01, 1'b0, "mul_ff");
    run_op(4'b0110, 8'd200, 8'd7, 9, 8'h04, 8'h1C, 1'b0, "divu_200_7");
    run_op(4'b0101, 8'hF9, 8'h02, 10, 8'hFF, 8'hFD, 1'b0, "div_m7_2");
    run_op(4'b0101, 8'h80, 8'hFF, 10, 8'h00, 8'h80, 1'b0, "div_wrap");
    run_op(4'b0101, 8'h33, 8'h00, 1, 8'h33, 8'hFF, 1'b1, "div_zero");
    run_op(4'b0100, 8'h03, 8'h05, 9, 8'h00, 8'h0F, 1'b0, "mul_clears_dbz");

    // MTLO in idle
    lo_we = 1'b1; wdata = 8'h5A;
    @(posedge clk); #2;
    lo_we = 1'b0;
    chk("mtlo_LO", LO, 8'h5A);

    // MUL while MTHI and a second start are held for the whole operation
    start = 1'b1; ALUop = 4'b0100; A = 8'h03; B = 8'h05;
    @(posedge clk); #2;
    ALUop = 4'b0110; A = 8'h09; B = 8'h02; hi_we = 1'b1; wdata = 8'h77;
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("busy_ignore_latency", n, 9);
    chk("busy_ignore_HI", HI, 8'h00);
    chk("busy_ignore_LO", LO, 8'h0F);
    @(posedge clk); #2;
    start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    chk("busy_ignore_idle", busy, 0);
    chk("busy_ignore_HI_after", HI, 8'h00);
    @(posedge clk); #2;

    // Reset during cycle 4 of a MUL
    start = 1'b1; ALUop = 4'b0100; A = 8'h12; B = 8'h34;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_HI", HI, 0);
    chk("abort_LO", LO, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #2;
    run_op(4'b0100, 8'h12, 8'h34, 9, 8'h03, 8'hA8, 1'b0, "mul_after_abort");

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 1500; i++) begin
      start = (($urandom % 3) == 0);
      case ($urandom % 5)
        0: ALUop = 4'b0100;
        1: ALUop = 4'b0101;
        2: ALUop = 4'b0110;
        3: ALUop = 4'b0101;
        default: ALUop = 4'($urandom);
      endcase
      A = pick(); B = pick();
      hi_we = (($urandom % 8) == 0);
      lo_we = (($urandom % 8) == 0);
      wdata = 8'($urandom);
      @(posedge clk); #2;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (12) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
